// File: rtl/addr_case_pkg.sv
// -----------------------------------------------------------------------------
// addr_case_pkg
//
// Shared definitions for the address-keyed case pipeline:
//   - mode_e       : the four data transform modes carried in the low address
//                    bits of every input word.
//   - MODE_LSB/MSB : where the mode field sits inside the address.
//   - ch_width()   : channel-tag width for a given channel count.
//
// Optional feature macro used by users of this package: ADDR_CASE_SAT_CNT_EN.
// -----------------------------------------------------------------------------
package addr_case_pkg;

    // Transform selected by the two low address bits.
    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_SAT  = 2'd1,
        MODE_INV  = 2'd2,
        MODE_SHR  = 2'd3
    } mode_e;

    // Mode field position inside the address word.
    localparam int MODE_LSB = 0;
    localparam int MODE_W   = 2;
    localparam int MODE_MSB = MODE_LSB + MODE_W - 1;

    // Width of the channel tag; a single channel still needs one bit so that
    // the tag vectors never collapse to zero width.
    function automatic int ch_width(input int num_ch);
        return (num_ch < 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/addr_case_pipe_sync_fifo_sa.sv
// -----------------------------------------------------------------------------
// sync_fifo_sa
//
// Show-ahead synchronous FIFO. The oldest entry is always presented on
// head_data, so a consumer sees the word in the same cycle that empty drops;
// pop simply retires it. Reusable outside this pipeline.
//
// Parameters:
//   WIDTH : entry width in bits.
//   DEPTH : number of entries; power of 2, at least 2, so pointers wrap
//           naturally.
//
// Ports:
//   sclk      in   clock, rising edge.
//   rst       in   synchronous active-high reset; empties the FIFO.
//   push      in   write push_data at this edge (ignored when full unless a
//                  pop happens in the same cycle).
//   push_data in   WIDTH  entry to write.
//   pop       in   retire the head entry at this edge (ignored when empty).
//   head_data out  WIDTH  oldest entry; reads as zero while empty.
//   empty     out  no entries stored.
//   full      out  DEPTH entries stored.
//   count     out  number of stored entries.
// -----------------------------------------------------------------------------
module sync_fifo_sa #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTRW  = $clog2(DEPTH),
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic [CNTW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNTW'(DEPTH));

    // A push into a full FIFO is still safe when the head is leaving in the
    // same cycle: the freed slot is the one the write pointer points at.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Zeroing the head while empty keeps the outputs clean after reset and
    // between bursts, without having to reset the storage array.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Storage array: written only, never reset.
    always_ff @(posedge sclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap
    // modulo DEPTH by plain overflow.
    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTRW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTRW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/addr_case_pipe.sv
// -----------------------------------------------------------------------------
// addr_case_pipe
//
// Accepts an (address, wide data) stream, decodes a channel tag and a
// transform mode from the address, narrows the data through the selected
// transform in one registered stage and queues the result in a show-ahead
// output FIFO with ready/valid handshakes on both sides.
//
// Address layout: [AW-1 -: CHW] = channel, [1:0] = mode (see addr_case_pkg).
// Modes: PASS = low bits, SAT = clamp to all-ones, INV = inverted low bits,
//        SHR = top DW_OUT bits.
//
// Parameters:
//   DW_IN  : input data width, must exceed DW_OUT.
//   DW_OUT : output data width.
//   AW     : address width.
//   NUM_CH : channel count, power of 2, at least 2.
//   DEPTH  : output FIFO depth, power of 2, at least 2.
//
// Ports:
//   sclk      in   clock, rising edge.
//   rst       in   synchronous active-high reset; drops all buffered words.
//   i_valid   in   input word present.
//   i_ready   out  an input word can be accepted this cycle.
//   i_addr    in   AW      channel / mode address.
//   i_data    in   DW_IN   input word.
//   i_ch_en   in   NUM_CH  per-channel enable, sampled at accept.
//   o_dv      out  output word valid.
//   o_ready   in   downstream accepts the output word.
//   o_data    out  DW_OUT  transformed word.
//   o_ch      out  CHW     channel tag of o_data.
//   o_sat_cnt out  16      saturation event counter (only with the macro
//                          ADDR_CASE_SAT_CNT_EN defined).
//
// Optional feature: define ADDR_CASE_SAT_CNT_EN to add o_sat_cnt, a sticky
// 16-bit count of accepted, enabled SAT-mode words that had to be clamped.
// -----------------------------------------------------------------------------
module addr_case_pipe
    import addr_case_pkg::*;
#(
    parameter  int DW_IN  = 10,
    parameter  int DW_OUT = 8,
    parameter  int AW     = 8,
    parameter  int NUM_CH = 4,
    parameter  int DEPTH  = 4,
    localparam int CHW    = ch_width(NUM_CH)
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [AW-1:0]     i_addr,
    input  logic [DW_IN-1:0]  i_data,
    input  logic [NUM_CH-1:0] i_ch_en,
    output logic              o_dv,
    input  logic              o_ready,
    output logic [DW_OUT-1:0] o_data,
    output logic [CHW-1:0]    o_ch
`ifdef ADDR_CASE_SAT_CNT_EN
   ,output logic [15:0]       o_sat_cnt
`endif
);

    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int OCCW  = CNTW + 1;
    localparam int SHIFT = DW_IN - DW_OUT;
    localparam int FW    = CHW + DW_OUT;

    // Decoded view of the word currently on the input.
    logic [CHW-1:0]    in_ch;
    mode_e             in_mode;
    logic              in_en;
    logic              sat_hit;
    logic [DW_IN-1:0]  shr_full;
    logic [DW_OUT-1:0] xform;
    logic              accept;

    // Registered compute stage.
    logic              stage_v;
    logic [DW_OUT-1:0] stage_data;
    logic [CHW-1:0]    stage_ch;

    // Output FIFO interface.
    logic [FW-1:0]     fifo_head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNTW-1:0]   fifo_count;
    logic              fifo_pop;
    logic [OCCW-1:0]   occupancy;

    // Only the channel and mode fields of the address carry meaning; the
    // remaining bits are deliberately ignored.
    logic              unused_addr;
    assign unused_addr = ^i_addr;

    assign in_ch    = i_addr[AW-1 -: CHW];
    assign in_mode  = mode_e'(i_addr[MODE_MSB:MODE_LSB]);
    assign in_en    = i_ch_en[in_ch];
    // Any set bit above the output width means the value exceeds the
    // largest representable output, i.e. it must be clamped in SAT mode.
    assign sat_hit  = |i_data[DW_IN-1:DW_OUT];
    assign shr_full = i_data >> SHIFT;

    // Transform the incoming word according to its address mode.
    always_comb begin
        xform = i_data[DW_OUT-1:0];
        unique case (in_mode)
            MODE_PASS: xform = i_data[DW_OUT-1:0];
            MODE_SAT:  xform = sat_hit ? '1 : i_data[DW_OUT-1:0];
            MODE_INV:  xform = ~i_data[DW_OUT-1:0];
            MODE_SHR:  xform = shr_full[DW_OUT-1:0];
            default:   xform = i_data[DW_OUT-1:0];
        endcase
    end

    // Input handshake. Room is counted over everything already committed to
    // the FIFO: the stored words plus the one sitting in the compute stage.
    // It does not credit a pop in the same cycle, which keeps i_ready free of
    // any combinational path from o_ready. The explicit full term is implied
    // by the occupancy test and only guards the push path.
    assign occupancy = OCCW'(fifo_count) + OCCW'(stage_v);
    assign i_ready   = !rst && !fifo_full && (occupancy < OCCW'(DEPTH));
    assign accept    = i_valid && i_ready;

    // Compute stage. Words on disabled channels are still accepted (the
    // source is never stalled by them) but never become valid.
    always_ff @(posedge sclk) begin
        if (rst) begin
            stage_v    <= 1'b0;
            stage_data <= '0;
            stage_ch   <= '0;
        end else if (accept) begin
            stage_v    <= in_en;
            stage_data <= xform;
            stage_ch   <= in_ch;
        end else begin
            stage_v    <= 1'b0;
        end
    end

    // Output queue; the head is presented directly on the outputs, so the
    // word and tag stay put while the consumer stalls.
    assign fifo_pop = o_dv && o_ready;

    sync_fifo_sa #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .sclk      (sclk),
        .rst       (rst),
        .push      (stage_v),
        .push_data ({stage_ch, stage_data}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign o_dv   = !fifo_empty;
    assign o_ch   = fifo_head[FW-1 -: CHW];
    assign o_data = fifo_head[DW_OUT-1:0];

`ifdef ADDR_CASE_SAT_CNT_EN
    // Clamp event counter: sticks at all-ones rather than wrapping so that a
    // long run never looks like a quiet one.
    always_ff @(posedge sclk) begin
        if (rst) begin
            o_sat_cnt <= '0;
        end else if (accept && in_en && (in_mode == MODE_SAT) && sat_hit
                     && (o_sat_cnt != 16'hFFFF)) begin
            o_sat_cnt <= o_sat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_addr_case_pipe.sv
// -----------------------------------------------------------------------------
// tb_addr_case_pipe
//
// Self-checking bench for addr_case_pipe at default parameters. A table of
// mode/channel vectors plus hand-written sequences for reset, channel
// disable, backpressure and mid-stream reset. Expected output words are
// queued when their input is accepted and compared when the DUT presents
// them. Honours ADDR_CASE_SAT_CNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_addr_case_pipe;

    localparam int DW_IN  = 10;
    localparam int DW_OUT = 8;
    localparam int AW     = 8;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;

    logic        tb_sclk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [7:0]  i_addr;
    logic [9:0]  i_data;
    logic [3:0]  i_ch_en;
    logic        o_dv;
    logic        o_ready;
    logic [7:0]  o_data;
    logic [1:0]  o_ch;
`ifdef ADDR_CASE_SAT_CNT_EN
    logic [15:0] o_sat_cnt;
`endif

    addr_case_pipe #(
        .DW_IN  (DW_IN),
        .DW_OUT (DW_OUT),
        .AW     (AW),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .sclk      (tb_sclk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .i_ch_en   (i_ch_en),
        .o_dv      (o_dv),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_ch      (o_ch)
`ifdef ADDR_CASE_SAT_CNT_EN
       ,.o_sat_cnt (o_sat_cnt)
`endif
    );

    always #5 tb_sclk = ~tb_sclk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
        int         drv;
        bit         lat;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [9:0] data;
        logic [7:0] exp_d;
        logic [1:0] exp_c;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Edge counter used to measure output latency.
    always @(posedge tb_sclk) cyc <= cyc + 1;

    // Compare one value and log a failure line when it differs.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Independent reference for the four transforms at default widths.
    function automatic logic [7:0] modelXform(input logic [9:0] d, input logic [1:0] m);
        case (m)
            2'd0:    return d[7:0];
            2'd1:    return (d > 10'd255) ? 8'hFF : d[7:0];
            2'd2:    return ~d[7:0];
            default: return d[9:2];
        endcase
    endfunction

    // Drive one word (called just after a rising edge) and hold it until it
    // is accepted; the expected output is queued at the accepting cycle.
    task automatic applyStimulus(input logic [7:0] addr, input logic [9:0] data,
                                 input logic [7:0] exp_d, input logic [1:0] exp_c,
                                 input bit exp_v, input bit lat, output bit accepted);
        i_addr   = addr;
        i_data   = data;
        i_valid  = 1'b1;
        accepted = 1'b0;
        for (int n = 0; n < 20 && !accepted; n++) begin
            @(negedge tb_sclk);
            if (i_ready === 1'b1) begin
                accepted = 1'b1;
                if (exp_v) sb.push_back('{data: exp_d, ch: exp_c, drv: cyc, lat: lat});
            end
            @(posedge tb_sclk);
            #1;
        end
        i_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait (bounded) for every queued word to come out, then clear the queue.
    task automatic waitDrain(input string name);
        for (int n = 0; n < 40 && sb.size() != 0; n++) begin
            @(posedge tb_sclk);
            #2;
        end
        checkOutput({name, "_drain_left"}, sb.size(), 32'd0);
        sb.delete();
    endtask

    // Output monitor: every word the DUT hands over must match the queue.
    always @(negedge tb_sclk) begin
        exp_t e;
        if (rst === 1'b0 && o_dv === 1'b1 && o_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", {31'd0, o_dv}, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_data", {24'd0, o_data}, {24'd0, e.data});
                checkOutput("out_ch", {30'd0, o_ch}, {30'd0, e.ch});
                if (e.lat) checkOutput("latency", cyc - e.drv, 32'd2);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc;
        int n_acc;

        vecs = '{
            '{8'h00, 10'h0FF, 8'hFF, 2'd0},
            '{8'h01, 10'h155, 8'hFF, 2'd0},
            '{8'h01, 10'h055, 8'h55, 2'd0},
            '{8'h02, 10'h055, 8'hAA, 2'd0},
            '{8'h03, 10'h3FC, 8'hFF, 2'd0},
            '{8'hC0, 10'h012, 8'h12, 2'd3},
            '{8'h03, 10'h155, 8'h55, 2'd0},
            '{8'h42, 10'h3F0, 8'h0F, 2'd1},
            '{8'h81, 10'h100, 8'hFF, 2'd2}
        };

        // Reset held for three edges with a word on the input.
        rst     = 1'b1;
        i_valid = 1'b1;
        i_addr  = 8'h01;
        i_data  = 10'h3FF;
        i_ch_en = 4'hF;
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_sclk);
            checkOutput("rst_i_ready", {31'd0, i_ready}, 32'd0);
            checkOutput("rst_o_dv", {31'd0, o_dv}, 32'd0);
        end
        checkOutput("rst_o_data", {24'd0, o_data}, 32'd0);
        checkOutput("rst_o_ch", {30'd0, o_ch}, 32'd0);
        @(posedge tb_sclk);
        #1;
        rst     = 1'b0;
        i_valid = 1'b0;
        @(negedge tb_sclk);
        checkOutput("post_rst_i_ready", {31'd0, i_ready}, 32'd1);
        repeat (3) begin
            @(negedge tb_sclk);
            checkOutput("post_rst_quiet", {31'd0, o_dv}, 32'd0);
        end
        @(posedge tb_sclk);
        #1;

        // Mode and channel vectors, back to back with o_ready high.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].exp_d, vecs[i].exp_c,
                          1'b1, 1'b1, acc);
        end
        waitDrain("modes");
`ifdef ADDR_CASE_SAT_CNT_EN
        checkOutput("sat_cnt_modes", {16'd0, o_sat_cnt}, 32'd2);
`endif

        // Channel 1 disabled: its word is taken but never emitted.
        i_ch_en = 4'b1101;
        applyStimulus(8'h00, 10'h033, 8'h33, 2'd0, 1'b1, 1'b1, acc);
        applyStimulus(8'h41, 10'h3FF, 8'hFF, 2'd1, 1'b0, 1'b0, acc);
        checkOutput("dis_accepted", {31'd0, acc}, 32'd1);
        applyStimulus(8'h02, 10'h0F0, 8'h0F, 2'd0, 1'b1, 1'b1, acc);
        waitDrain("dis");
        repeat (3) begin
            @(negedge tb_sclk);
            checkOutput("dis_quiet", {31'd0, o_dv}, 32'd0);
        end
`ifdef ADDR_CASE_SAT_CNT_EN
        checkOutput("sat_cnt_dis", {16'd0, o_sat_cnt}, 32'd2);
`endif
        i_ch_en = 4'hF;
        @(posedge tb_sclk);
        #1;

        // Backpressure: six cycles of offered words with the consumer stalled.
        o_ready = 1'b0;
        n_acc   = 0;
        i_valid = 1'b1;
        i_addr  = 8'h00;
        i_data  = 10'(n_acc * 33 + 3);
        for (int c = 0; c < 6; c++) begin
            @(negedge tb_sclk);
            if (i_ready === 1'b1) begin
                sb.push_back('{data: modelXform(i_data, 2'd0), ch: 2'd0, drv: cyc, lat: 1'b0});
                n_acc++;
            end
            @(posedge tb_sclk);
            #1;
            i_data = 10'(n_acc * 33 + 3);
        end
        i_valid = 1'b0;
        checkOutput("bp_accepts", n_acc, 32'd4);
        @(negedge tb_sclk);
        checkOutput("bp_i_ready_full", {31'd0, i_ready}, 32'd0);
        checkOutput("bp_hold_dv", {31'd0, o_dv}, 32'd1);
        if (sb.size() > 0) checkOutput("bp_hold_data", {24'd0, o_data}, {24'd0, sb[0].data});
        @(negedge tb_sclk);
        if (sb.size() > 0) checkOutput("bp_hold_data2", {24'd0, o_data}, {24'd0, sb[0].data});
        @(posedge tb_sclk);
        #1;
        o_ready = 1'b1;
        waitDrain("bp");
        @(negedge tb_sclk);
        checkOutput("bp_i_ready_back", {31'd0, i_ready}, 32'd1);
        @(posedge tb_sclk);
        #1;

        // Mid-stream reset with three clamped SAT words buffered.
        o_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(8'h81, 10'(10'h200 + k), modelXform(10'(10'h200 + k), 2'd1),
                          2'd2, 1'b1, 1'b0, acc);
        end
        repeat (2) @(posedge tb_sclk);
        #1;
        @(negedge tb_sclk);
        checkOutput("mr_buffered_dv", {31'd0, o_dv}, 32'd1);
`ifdef ADDR_CASE_SAT_CNT_EN
        checkOutput("sat_cnt_before_rst", {16'd0, o_sat_cnt}, 32'd5);
`endif
        @(posedge tb_sclk);
        #1;
        rst = 1'b1;
        @(posedge tb_sclk);
        #1;
        rst = 1'b0;
        sb.delete();
        @(negedge tb_sclk);
        checkOutput("mr_o_dv", {31'd0, o_dv}, 32'd0);
        checkOutput("mr_o_data", {24'd0, o_data}, 32'd0);
        checkOutput("mr_i_ready", {31'd0, i_ready}, 32'd1);
`ifdef ADDR_CASE_SAT_CNT_EN
        checkOutput("sat_cnt_after_rst", {16'd0, o_sat_cnt}, 32'd0);
`endif
        @(posedge tb_sclk);
        #1;
        o_ready = 1'b1;
        repeat (4) begin
            @(negedge tb_sclk);
            checkOutput("mr_quiet", {31'd0, o_dv}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
